// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback over the
// shared datapath and decodes every mux select, write enable and ALU operation.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   op_legal;

    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                      (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
        if (reset) begin
            state_d   = S_FETCH;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        illegal_q <= illegal_d;
    end

    // While reset is high the outputs show FETCH, with enables gated off below.
    state_e     dec_state;
    logic [1:0] alu_op;
    logic       branch, pc_update, ir_wr, reg_wr, mem_wr, done;

    assign dec_state = reset ? S_FETCH : state_q;

    always_comb begin
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        branch     = 1'b0;
        pc_update  = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        done       = 1'b0;
        case (dec_state)
            S_FETCH: begin
                ir_wr = 1'b1; alu_src_b = 2'b10; result_src = 2'b10; pc_update = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01; alu_src_b = 2'b01; done = ~op_legal;
            end
            S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB:    begin result_src = 2'b01; reg_wr = 1'b1; done = 1'b1; end
            S_MEMWRITE: begin adr_src = 1'b1; mem_wr = 1'b1; done = 1'b1; end
            S_EXECUTER: begin alu_src_a = 2'b10; alu_op = 2'b10; end
            S_EXECUTEI: begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
            S_ALUWB:    begin reg_wr = 1'b1; done = 1'b1; end
            S_BEQ: begin
                alu_src_a = 2'b10; alu_op = 2'b01; branch = 1'b1; done = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01; alu_src_b = 2'b10; pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign pc_write      = ~reset & (pc_update | (branch & zero));
    assign ir_write      = ~reset & ir_wr;
    assign reg_write     = ~reset & reg_wr;
    assign mem_write     = ~reset & mem_wr;
    assign instr_done    = ~reset & done;
    assign illegal_instr = illegal_q;
    assign state         = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream checked against a per-instruction model of the
// expected state walk and control outputs.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .reg_write(reg_write), .instr_done(instr_done), .illegal_instr(illegal_instr),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, adr, memw, irw;
        logic [1:0] rs, a, b;
        logic [2:0] alu;
        logic       regw, done;
    } ctl_t;

    typedef enum int {
        M_LW, M_SW, M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL,
        M_ADDI, M_ANDI, M_ORI, M_SLTI, M_XORI, M_BEQ, M_JAL, M_ILL
    } mn_e;

    int   n_chk = 0;
    int   n_fail = 0;
    logic exp_ill = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t dut_ctl();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_control, reg_write, instr_done};
    endfunction

    // What each step of an instruction is supposed to drive.
    function automatic ctl_t exp_ctl(input int st, input logic [2:0] ex_alu,
                                     input logic z, input logic ill);
        ctl_t c = '0;
        case (st)
            0:  begin c.pcw = 1; c.irw = 1; c.b = 2; c.rs = 2; end
            1:  begin c.a = 1; c.b = 1; c.done = ill; end
            2:  begin c.a = 2; c.b = 1; end
            3:  c.adr = 1;
            4:  begin c.rs = 1; c.regw = 1; c.done = 1; end
            5:  begin c.adr = 1; c.memw = 1; c.done = 1; end
            6:  begin c.a = 2; c.alu = ex_alu; end
            7:  begin c.a = 2; c.b = 1; c.alu = ex_alu; end
            8:  begin c.regw = 1; c.done = 1; end
            9:  begin c.a = 2; c.alu = 3'b001; c.pcw = z; c.done = 1; end
            10: begin c.a = 1; c.b = 2; c.pcw = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t reset_ctl();
        ctl_t c = exp_ctl(0, 3'b000, 1'b0, 1'b0);
        c.pcw = 0;
        c.irw = 0;
        return c;
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // zm: 0 random zero, 1 force 1, 2 force 0. rst_mid asserts reset on entering MEMREAD.
    task automatic run_instr(input mn_e m, input int zm, input bit rst_mid, input logic [6:0] ill_op);
        int         seq[$];
        logic [2:0] ex = 3'b000;
        logic [1:0] imm = 2'b00;
        bit         ill = 0;
        logic       z;
        logic [6:0] o;
        logic [2:0] f3 = 3'($urandom_range(0, 7));
        logic       f7 = 1'($urandom_range(0, 1));
        case (m)
            M_LW:   begin o = 7'b0000011; seq = '{0, 1, 2, 3, 4}; end
            M_SW:   begin o = 7'b0100011; imm = 2'b01; seq = '{0, 1, 2, 5}; end
            M_ADD:  begin o = 7'b0110011; f3 = 3'b000; f7 = 0; seq = '{0, 1, 6, 8}; end
            M_SUB:  begin o = 7'b0110011; f3 = 3'b000; f7 = 1; ex = 3'b001; seq = '{0, 1, 6, 8}; end
            M_AND:  begin o = 7'b0110011; f3 = 3'b111; ex = 3'b010; seq = '{0, 1, 6, 8}; end
            M_OR:   begin o = 7'b0110011; f3 = 3'b110; ex = 3'b011; seq = '{0, 1, 6, 8}; end
            M_SLT:  begin o = 7'b0110011; f3 = 3'b010; ex = 3'b101; seq = '{0, 1, 6, 8}; end
            M_SLL:  begin o = 7'b0110011; f3 = 3'b001; seq = '{0, 1, 6, 8}; end
            M_ADDI: begin o = 7'b0010011; f3 = 3'b000; seq = '{0, 1, 7, 8}; end
            M_ANDI: begin o = 7'b0010011; f3 = 3'b111; ex = 3'b010; seq = '{0, 1, 7, 8}; end
            M_ORI:  begin o = 7'b0010011; f3 = 3'b110; ex = 3'b011; seq = '{0, 1, 7, 8}; end
            M_SLTI: begin o = 7'b0010011; f3 = 3'b010; ex = 3'b101; seq = '{0, 1, 7, 8}; end
            M_XORI: begin o = 7'b0010011; f3 = 3'b100; seq = '{0, 1, 7, 8}; end
            M_BEQ:  begin o = 7'b1100011; imm = 2'b10; seq = '{0, 1, 9}; end
            M_JAL:  begin o = 7'b1101111; imm = 2'b11; seq = '{0, 1, 10, 8}; end
            default: begin o = ill_op; ill = 1; seq = '{0, 1}; end
        endcase
        op = o; funct3 = f3; funct7b5 = f7;
        foreach (seq[i]) begin
            z = (zm == 1) ? 1'b1 : (zm == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            zero = z;
            if (rst_mid && seq[i] == 3) begin
                reset = 1;
                @(negedge clk);
                chk("ctl_in_reset", {16'd0, dut_ctl()}, {16'd0, reset_ctl()});
                @(posedge clk); #1;
                reset = 0;
                exp_ill = 0;
                @(negedge clk);
                chk("state_after_reset", {28'd0, state}, 32'd0);
                chk("illegal_after_reset", {31'd0, illegal_instr}, 32'd0);
                // Leave in the FETCH cycle so the next instruction starts cleanly.
                return;
            end
            @(negedge clk);
            chk($sformatf("state m%0d i%0d", m, i), {28'd0, state}, seq[i]);
            chk($sformatf("ctl m%0d st%0d", m, seq[i]), {16'd0, dut_ctl()},
                {16'd0, exp_ctl(seq[i], ex, z, ill)});
            chk($sformatf("imm_src m%0d", m), {30'd0, imm_src}, {30'd0, imm});
            chk("illegal_instr", {31'd0, illegal_instr}, {31'd0, exp_ill});
            @(posedge clk); #1;
            if (ill && seq[i] == 1) exp_ill = 1;
        end
    endtask

    task automatic next_fetch_align();
        // Mid-instruction reset returns at a negedge inside FETCH; step to its posedge+1
        // and replay FETCH expectations in the following instruction via a fresh reset-free start.
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [6:0] rop;
        reset = 1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        @(negedge clk);
        chk("reset1_ctl", {16'd0, dut_ctl()}, {16'd0, reset_ctl()});
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset2_state", {28'd0, state}, 32'd0);
        chk("reset2_ctl", {16'd0, dut_ctl()}, {16'd0, reset_ctl()});
        chk("reset2_illegal", {31'd0, illegal_instr}, 32'd0);
        @(posedge clk); #1;
        reset = 0;

        run_instr(M_LW, 0, 0, 7'd0);
        run_instr(M_SW, 0, 0, 7'd0);
        run_instr(M_BEQ, 1, 0, 7'd0);
        run_instr(M_BEQ, 2, 0, 7'd0);
        run_instr(M_SUB, 0, 0, 7'd0);
        op = 7'b0010011;
        run_instr(M_ADDI, 0, 0, 7'd0);
        run_instr(M_OR, 0, 0, 7'd0);
        run_instr(M_AND, 0, 0, 7'd0);
        run_instr(M_SLT, 0, 0, 7'd0);
        run_instr(M_JAL, 0, 0, 7'd0);
        run_instr(M_ILL, 0, 0, 7'b1111111);
        run_instr(M_ADD, 0, 0, 7'd0);
        run_instr(M_ILL, 0, 0, 7'b0000000);
        // lw aborted by reset in MEMREAD: the DUT is now in FETCH (state 0 checked),
        // so finish that FETCH cycle and let DECODE decode a fresh lw.
        run_instr(M_LW, 0, 1, 7'd0);
        op = 7'b0000011;
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_reset_decode", {28'd0, state}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_reset_memadr", {28'd0, state}, 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_reset_memread", {28'd0, state}, 32'd3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_reset_memwb", {28'd0, state}, 32'd4);
        @(posedge clk); #1;

        for (int k = 0; k < 300; k++) begin
            mn_e m = mn_e'($urandom_range(0, 15));
            do rop = 7'($urandom); while (is_legal(rop));
            run_instr(m, 0, 0, rop);
        end
        @(negedge clk);
        chk("final_state", {28'd0, state}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences the shared RISC-V datapath (PC register, instruction/data memory, register file, ALU, immediate extender) over multiple cycles per instruction. It replaces the hardwired control constants currently tied into the datapath. It decodes the latched instruction fields and drives every mux select, write enable and ALU operation. Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = Result
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register and OldPC enable
- result_src  out  2  00 = ALUOut reg, 01 = memory data reg, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1 reg
- alu_src_b  out  2  00 = RD2 reg, 01 = ImmExt, 10 = constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  extender select: 00 I, 01 S, 10 B, 11 J
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_instr  out  1  sticky; set on an unsupported opcode in DECODE
- state  out  4  current state encoding, for debug and the testbench

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Encodings 11-15 go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE branches on op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> FETCH, and illegal_instr is set.
  - MEMADR -> MEMREAD if op = 0000011, otherwise MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER and EXECUTEI -> ALUWB.
  - JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Outputs are Moore, decoded from state. Every output not listed for a state is 0.
  - FETCH: ir_write=1, a=00, b=10, alu_op=00, result_src=10, pc_update=1.
  - DECODE: a=01, b=01, alu_op=00 (precomputes the branch target).
  - MEMADR: a=10, b=01, alu_op=00.
  - MEMREAD: result_src=00, adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1.
  - EXECUTER: a=10, b=00, alu_op=10.
  - EXECUTEI: a=10, b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1.
- pc_write = pc_update | (branch & zero).
- ALU decoder (combinational):
  - alu_op 00 -> 000; alu_op 01 -> 001.
  - alu_op 10, by funct3:
    - 000 -> 001 if {op[5], funct7b5} = 11, else 000.
    - 010 -> 101.
    - 110 -> 011.
    - 111 -> 010.
    - any other funct3 -> 000.
- imm_src decodes from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, anything else 00.
- instr_done = 1 in MEMWB, MEMWRITE, ALUWB and BEQ, and in DECODE when op is illegal.

## Timing
- While reset is high:
  - state holds at FETCH.
  - pc_write, ir_write, reg_write, mem_write, instr_done are forced to 0.
  - illegal_instr is cleared to 0.
  - Other outputs show their FETCH values.
- Reset asserted mid-instruction: on the next edge state = FETCH. No write enable is asserted in the reset cycle.
- The first FETCH writes happen on the first edge after reset is deasserted.
- Cycles per instruction, counted FETCH to last state inclusive: lw 5; sw, R-type, I-type and jal 4; beq 3; illegal op 2.
- op, funct3 and funct7b5 are valid from DECODE onward; they are not sampled in FETCH.
- zero is sampled combinationally in BEQ only.
- illegal_instr sets on the edge that leaves the illegal DECODE. It stays 1 until reset; further illegal ops keep it at 1.

## Test plan
- Reset for 2 cycles, then release -> state = 0 and all write enables 0 during reset. Next state sequence is 0,1.
- lw (op 0000011) -> states 0,1,2,3,4,0. reg_write=1 only in state 4, with result_src=01. instr_done pulses once.
- sw (op 0100011) -> states 0,1,2,5,0. mem_write=1 only in state 5, with adr_src=1. imm_src=01.
- beq with zero=1 -> pc_write=1 in states 0 and 9. beq with zero=0 -> pc_write=1 in state 0 only. alu_control=001 in state 9.
- R-type sub (op 0110011, funct3 000, funct7b5 1) -> alu_control=001 in state 6. addi with funct7b5=1 -> alu_control=000. or -> 011; and -> 010; slt -> 101.
- op 1111111 -> state 0,1,0, instr_done=1 in DECODE, illegal_instr=1 afterwards. Reset mid-lw (in state 3) -> state 0 next edge, illegal_instr=0.
